// File: rtl/uart8_pkg.sv
// uart8_pkg: shared FSM state type, oversample ratio and clock divisor helper
package uart8_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  localparam int OVERSAMPLE = 16;
  function automatic int divisor(input int clock_rate, input int rate);
    return clock_rate / rate;
  endfunction
endpackage

// File: rtl/uart8_if.sv
// uart8_if: serial lines plus rx/tx handshake signals of the uart8 block
interface uart8_if;
  logic       rxEn;
  logic       rxIn;
  logic       rxBusy;
  logic       rxDone;
  logic       rxErr;
  logic [7:0] rxOut;
  logic       txEn;
  logic       txStart;
  logic [7:0] txIn;
  logic       txBusy;
  logic       txDone;
  logic       txOut;
  modport slave (
    input  rxEn, rxIn, txEn, txStart, txIn,
    output rxBusy, rxDone, rxErr, rxOut, txBusy, txDone, txOut
  );
  modport master (
    output rxEn, rxIn, txEn, txStart, txIn,
    input  rxBusy, rxDone, rxErr, rxOut, txBusy, txDone, txOut
  );
endinterface

// File: rtl/uart8_baud.sv
// baud_rate_generator: rx oversample tick and tx bit tick, each held at phase zero while its clear is high
module baud_rate_generator
  import uart8_pkg::*;
#(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_clr_i,
  input  logic tx_clr_i,
  output logic rx_tick_o,
  output logic tx_tick_o
);
  localparam int RX_DIV = divisor(CLOCK_RATE, OVERSAMPLE * BAUD_RATE);
  localparam int TX_DIV = divisor(CLOCK_RATE, BAUD_RATE);
  localparam int RXW = $clog2(RX_DIV + 1);
  localparam int TXW = $clog2(TX_DIV + 1);
  logic [RXW-1:0] rx_cnt_q, rx_cnt_d;
  logic [TXW-1:0] tx_cnt_q, tx_cnt_d;
  assign rx_tick_o = rx_cnt_q == RXW'(RX_DIV - 1);
  assign tx_tick_o = tx_cnt_q == TXW'(TX_DIV - 1);
  // next count: restart on clear or on reaching the divisor
  always_comb begin
    rx_cnt_d = (rx_clr_i || rx_tick_o) ? '0 : rx_cnt_q + 1'b1;
    tx_cnt_d = (tx_clr_i || tx_tick_o) ? '0 : tx_cnt_q + 1'b1;
  end
  // divider counters
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end
endmodule

// File: rtl/uart8.sv
// uart8: 8N1 UART receiver; define UART8_TX_EN to compile in the transmitter
module uart8
  import uart8_pkg::*;
#(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600
) (
  input logic    clk,
  input logic    reset,
  uart8_if.slave bus
);
  state_e     rx_q, rx_d;
  logic [1:0] sync_q, sync_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, out_q, out_d;
  logic       done_q, done_d, err_q, err_d;
  logic       rx_s, rx_tick, tx_tick, tx_clr;
  baud_rate_generator #(.CLOCK_RATE(CLOCK_RATE), .BAUD_RATE(BAUD_RATE)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .rx_clr_i (rx_q == IDLE),
    .tx_clr_i (tx_clr),
    .rx_tick_o(rx_tick),
    .tx_tick_o(tx_tick)
  );
  assign rx_s       = sync_q[1];
  assign bus.rxBusy = rx_q != IDLE;
  assign bus.rxDone = done_q;
  assign bus.rxErr  = err_q;
  assign bus.rxOut  = out_q;
  // rx state and data registers; synchronizer resets to idle-high
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      rx_q    <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      rx_q    <= rx_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  // rx next state: mid-start check at 8 ticks, then one sample every 16 ticks
  always_comb begin
    sync_d  = {sync_q[0], bus.rxIn};
    rx_d    = rx_q;
    tick_d  = rx_tick ? tick_q + 4'd1 : tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    out_d   = out_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (!bus.rxEn) rx_d = IDLE;
    else case (rx_q)
      IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        rx_d   = rx_s ? IDLE : START;
      end
      START: if (rx_tick && tick_q == 4'd7) begin
        rx_d   = rx_s ? IDLE : DATA;
        tick_d = '0;
      end
      DATA: if (rx_tick && tick_q == 4'd15) begin
        shift_d = {rx_s, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        rx_d    = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (rx_tick && tick_q == 4'd15) begin
        rx_d   = IDLE;
        out_d  = rx_s ? shift_q : out_q;
        done_d = rx_s;
        err_d  = !rx_s;
      end
      default: rx_d = IDLE;
    endcase
  end
`ifdef UART8_TX_EN
  state_e     tx_q, tx_d;
  logic [7:0] txsh_q, txsh_d;
  logic [2:0] txbit_q, txbit_d;
  logic       txdone_q, txdone_d, txout_q, txout_d;
  assign tx_clr     = tx_q == IDLE;
  assign bus.txBusy = tx_q != IDLE;
  assign bus.txDone = txdone_q;
  assign bus.txOut  = txout_q;
  // tx state and data registers; line output registered to stay glitch-free
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_q     <= IDLE;
      txsh_q   <= '0;
      txbit_q  <= '0;
      txdone_q <= 1'b0;
      txout_q  <= 1'b1;
    end else begin
      tx_q     <= tx_d;
      txsh_q   <= txsh_d;
      txbit_q  <= txbit_d;
      txdone_q <= txdone_d;
      txout_q  <= txout_d;
    end
  end
  // tx next state: one bit per tx tick, txStart only honoured from IDLE
  always_comb begin
    tx_d     = tx_q;
    txsh_d   = txsh_q;
    txbit_d  = txbit_q;
    txdone_d = 1'b0;
    case (tx_q)
      IDLE: if (bus.txEn && bus.txStart) begin
        tx_d    = START;
        txsh_d  = bus.txIn;
        txbit_d = '0;
      end
      START: tx_d = tx_tick ? DATA : START;
      DATA: if (tx_tick) begin
        txsh_d  = txsh_q >> 1;
        txbit_d = txbit_q + 3'd1;
        tx_d    = txbit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (tx_tick) begin
        tx_d     = IDLE;
        txdone_d = 1'b1;
      end
      default: tx_d = IDLE;
    endcase
    txout_d = tx_d == START ? 1'b0 : tx_d == DATA ? txsh_d[0] : 1'b1;
  end
`else
  logic unused_tx;
  assign tx_clr     = 1'b1;
  assign bus.txBusy = 1'b0;
  assign bus.txDone = 1'b0;
  assign bus.txOut  = 1'b1;
  assign unused_tx  = &{1'b0, tx_tick, bus.txEn, bus.txStart, bus.txIn};
`endif
endmodule

// File: tb/tb_uart8.sv
// tb_uart8: randomized self-checking bench for uart8 against a frame-level reference model
module tb_uart8;
  localparam int PER = 1250;
  localparam int TICK = 78;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [7:0] exp_out = 8'h00;
  logic busy_mid;
  uart8_if bus();
  uart8 #(.CLOCK_RATE(12000000), .BAUD_RATE(9600)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.rxDone) done_cnt++;
    if (bus.rxErr) err_cnt++;
  end

  task automatic send_frame(input logic [7:0] b, input int per, input logic stop, input int stop_len);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rxIn = f[i];
      for (int k = 0; k < (i == 9 ? stop_len : per); k++) begin
        if (i == 5 && k == per / 2) busy_mid = bus.rxBusy;
        @(negedge clk);
      end
    end
    bus.rxIn = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.rxBusy !== 1'b0) begin n_bad++; $display("FAIL reset_rxBusy got %b want 0", bus.rxBusy); end
    n_cmp++; if (bus.rxDone !== 1'b0) begin n_bad++; $display("FAIL reset_rxDone got %b want 0", bus.rxDone); end
    n_cmp++; if (bus.rxErr !== 1'b0) begin n_bad++; $display("FAIL reset_rxErr got %b want 0", bus.rxErr); end
    n_cmp++; if (bus.rxOut !== 8'h00) begin n_bad++; $display("FAIL reset_rxOut got %h want 00", bus.rxOut); end
    n_cmp++; if (bus.txOut !== 1'b1) begin n_bad++; $display("FAIL reset_txOut got %b want 1", bus.txOut); end
    n_cmp++; if (bus.txBusy !== 1'b0) begin n_bad++; $display("FAIL reset_txBusy got %b want 0", bus.txBusy); end
    n_cmp++; if (bus.txDone !== 1'b0) begin n_bad++; $display("FAIL reset_txDone got %b want 0", bus.txDone); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // nominal, 3% slow, bad stop bit (held low past the sample point only), random byte at random +-2% rate
  task automatic test_rx_frames();
    logic [7:0] bytes [4];
    int pers [4];
    logic stops [4];
    int d0, e0;
    bytes = '{8'h35, 8'h35, 8'hA5, 8'($urandom)};
    pers  = '{PER, 1290, PER, 1225 + int'($urandom_range(0, 50))};
    stops = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int c = 0; c < 4; c++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      busy_mid = 1'b0;
      send_frame(bytes[c], pers[c], stops[c], stops[c] ? pers[c] : pers[c] * 3 / 4);
      repeat (stops[c] ? 20 : 700) @(negedge clk);
      if (stops[c]) exp_out = bytes[c];
      n_cmp++; if (bus.rxOut !== exp_out) begin n_bad++; $display("FAIL rx_out[%0d] got %h want %h", c, bus.rxOut, exp_out); end
      n_cmp++; if (done_cnt - d0 != int'(stops[c])) begin n_bad++; $display("FAIL rx_done_pulses[%0d] got %0d want %0d", c, done_cnt - d0, int'(stops[c])); end
      n_cmp++; if (err_cnt - e0 != int'(!stops[c])) begin n_bad++; $display("FAIL rx_err_pulses[%0d] got %0d want %0d", c, err_cnt - e0, int'(!stops[c])); end
      n_cmp++; if (busy_mid !== 1'b1) begin n_bad++; $display("FAIL rx_busy_mid[%0d] got %b want 1", c, busy_mid); end
      n_cmp++; if (bus.rxBusy !== 1'b0) begin n_bad++; $display("FAIL rx_busy_after[%0d] got %b want 0", c, bus.rxBusy); end
    end
  endtask

  task automatic test_glitch();
    int d0, e0, drop;
    d0 = done_cnt;
    e0 = err_cnt;
    drop = -1;
    bus.rxIn = 1'b0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (k == 299) bus.rxIn = 1'b1;
      if (k == 100) begin
        n_cmp++; if (bus.rxBusy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_seen got %b want 1", bus.rxBusy); end
      end
      if (k > 100 && drop < 0 && bus.rxBusy === 1'b0) drop = k;
    end
    n_cmp++; if (drop < 0 || drop > 8 * TICK + 10) begin n_bad++; $display("FAIL glitch_busy_drop got cycle %0d want 0..%0d", drop, 8 * TICK + 10); end
    n_cmp++; if (done_cnt != d0) begin n_bad++; $display("FAIL glitch_done got %0d want 0", done_cnt - d0); end
    n_cmp++; if (err_cnt != e0) begin n_bad++; $display("FAIL glitch_err got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_reset_mid();
    logic [9:0] f;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    f = {1'b1, 8'($urandom), 1'b0};
    for (int i = 0; i < 5; i++) begin
      bus.rxIn = f[i];
      repeat (PER) @(negedge clk);
    end
    n_cmp++; if (bus.rxBusy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before got %b want 1", bus.rxBusy); end
    reset = 1'b1;
    bus.rxIn = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_out = 8'h00;
    n_cmp++; if (bus.rxBusy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", bus.rxBusy); end
    n_cmp++; if (bus.rxOut !== exp_out) begin n_bad++; $display("FAIL rstmid_rxOut got %h want %h", bus.rxOut, exp_out); end
    repeat (6000) @(negedge clk);
    n_cmp++; if (done_cnt != d0 || err_cnt != e0) begin n_bad++; $display("FAIL rstmid_pulses got done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0); end
    n_cmp++; if (bus.rxOut !== exp_out) begin n_bad++; $display("FAIL rstmid_rxOut_hold got %h want %h", bus.rxOut, exp_out); end
  endtask

  // tx frame of 0xA5 with extra txStart requests while busy, concurrently with an rx frame
  task automatic test_tx_concurrent();
    logic [9:0] tf;
    logic [7:0] rb;
    logic exp_o, exp_b, exp_d;
    int d0;
    tf = {1'b1, 8'hA5, 1'b0};
    rb = 8'($urandom);
    d0 = done_cnt;
    bus.txEn = 1'b1;
    bus.txIn = 8'hA5;
    bus.txStart = 1'b1;
    @(negedge clk);
    bus.txStart = 1'b0;
    bus.txIn = 8'h3C;
    fork
      send_frame(rb, PER, 1'b1, PER);
      for (int k = 0; k < 12503; k++) begin
        if (k != 0) @(negedge clk);
`ifdef UART8_TX_EN
        exp_o = k < 10 * PER ? tf[k / PER] : 1'b1;
        exp_b = k < 10 * PER;
        exp_d = k == 10 * PER;
`else
        exp_o = 1'b1;
        exp_b = 1'b0;
        exp_d = 1'b0;
`endif
        if (k % PER == 0 || k % PER == PER / 2 || k % PER == PER - 1 || k >= 10 * PER - 1) begin
          n_cmp++;
          if ({bus.txOut, bus.txBusy, bus.txDone} !== {exp_o, exp_b, exp_d}) begin
            n_bad++;
            $display("FAIL tx_line@%0d got out/busy/done %b%b%b want %b%b%b", k, bus.txOut, bus.txBusy, bus.txDone, exp_o, exp_b, exp_d);
          end
        end
        if (k == 3000 || k == 10 * PER - 1) begin bus.txStart = 1'b1; bus.txIn = 8'hFF; end
        if (k == 3001 || k == 10 * PER) bus.txStart = 1'b0;
      end
    join
    bus.txEn = 1'b0;
    repeat (20) @(negedge clk);
    exp_out = rb;
    n_cmp++; if (bus.rxOut !== exp_out) begin n_bad++; $display("FAIL conc_rxOut got %h want %h", bus.rxOut, exp_out); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL conc_rxDone got %0d want 1", done_cnt - d0); end
  endtask

  initial begin
    bus.rxEn = 1'b1;
    bus.rxIn = 1'b1;
    bus.txEn = 1'b0;
    bus.txStart = 1'b0;
    bus.txIn = 8'h00;
    test_reset();
    test_rx_frames();
    test_glitch();
    test_reset_mid();
    test_tx_concurrent();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart8.md
UART8 -- requirements
Module: uart8

Interface
REQ-001 Parameter CLOCK_RATE, default 12000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line bit rate in bits/s.
REQ-003 Port clk  in  1  single system clock; all logic is on the rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port rxEn  in  1  receiver enable.
REQ-006 Port rxIn  in  1  serial receive line; idle is high.
REQ-007 Port rxBusy  out  1  a receive frame is in progress.
REQ-008 Port rxDone  out  1  one-cycle pulse when a valid byte is received.
REQ-009 Port rxErr  out  1  one-cycle pulse on a framing error.
REQ-010 Port rxOut  out  8  last valid received byte.
REQ-011 Port txEn  in  1  transmitter enable.
REQ-012 Port txStart  in  1  request to send txIn.
REQ-013 Port txIn  in  8  byte to transmit.
REQ-014 Port txBusy  out  1  a transmit frame is in progress.
REQ-015 Port txDone  out  1  one-cycle pulse after the stop bit completes.
REQ-016 Port txOut  out  1  serial transmit line; idle is high.

Function
REQ-017 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-018 Tx bit period SHALL be CLOCK_RATE/BAUD_RATE clocks, integer-truncated (default 1250).
REQ-019 Rx oversample tick SHALL occur every CLOCK_RATE/(16*BAUD_RATE) clocks, integer-truncated (default 78).
REQ-020 rxIn SHALL pass through a 2-flop synchronizer; an X or undriven level before the first edge SHALL be treated as idle-high.
REQ-021 Rx states SHALL be IDLE, START, DATA, STOP.
REQ-022 Rx IDLE SHALL move to START when rxEn=1 and the synchronized rxIn=0.
REQ-023 In START, the line SHALL be sampled after 8 ticks; if rxIn=0 go to DATA, otherwise return to IDLE silently (glitch rejection).
REQ-024 In DATA, each bit SHALL be sampled every 16 ticks and shifted in LSB first; after 8 bits go to STOP.
REQ-025 In STOP, the line SHALL be sampled after 16 ticks.
REQ-026 If the stop sample is 1, rxOut SHALL update and rxDone SHALL pulse for one cycle.
REQ-027 If the stop sample is 0, rxErr SHALL pulse for one cycle and rxOut SHALL be left unchanged.
REQ-028 After STOP, rx SHALL return to IDLE; rxOut SHALL hold its value until the next valid byte.
REQ-029 rxBusy SHALL be 1 in START, DATA and STOP.
REQ-030 Dropping rxEn mid-frame SHALL abort rx to IDLE with no rxDone or rxErr.
REQ-031 The receiver SHALL tolerate at least ±3% baud mismatch.
REQ-032 Tx states SHALL be IDLE, START, DATA, STOP.
REQ-033 When txEn=1, txStart=1 and tx is IDLE, the transmitter SHALL latch txIn and begin the start bit on the next cycle.
REQ-034 txStart SHALL be ignored while txBusy=1 or txEn=0.
REQ-035 txBusy SHALL be 1 from START through the end of STOP.
REQ-036 txDone SHALL pulse for one cycle as tx returns to IDLE.
REQ-037 Rx and tx SHALL operate independently and concurrently.

Reset
REQ-038 On reset, both FSMs SHALL enter IDLE and all counters SHALL clear.
REQ-039 On reset, rxOut SHALL be 0x00, txOut SHALL be 1, and all busy/done/error outputs SHALL be 0.
REQ-040 Reset mid-frame SHALL abort the frame with no done or error pulse.

Configuration
REQ-041 With macro UART8_TX_EN defined, the transmitter SHALL be compiled in.
REQ-042 Without UART8_TX_EN, tx logic SHALL be omitted, with txOut=1 and txBusy=txDone=0 constant; tx inputs SHALL remain as ports but be ignored.

Structure
REQ-043 Package uart8_pkg SHALL hold the rx/tx state enum, the OVERSAMPLE=16 constant and the divisor-calculation function.
REQ-044 Sub-module baud_rate_generator SHALL produce the rx oversample tick and the tx bit tick; rx and tx FSMs SHALL be in the top level.

Verification
REQ-045 Scenario: rxEn=1, frame 0x35 at 9600 baud (1250 clks/bit) -> rxOut=0x35, one rxDone pulse, rxErr=0.
REQ-046 Scenario: frame 0x35 sent with a 3% slow bit period (~1290 clks/bit) -> rxOut=0x35, rxDone pulse.
REQ-047 Scenario: frame 0xA5 with stop bit held 0 -> one rxErr pulse, no rxDone, rxOut unchanged.
REQ-048 Scenario: 300-clock low glitch on rxIn -> rxBusy drops within 8 ticks, no rxDone or rxErr.
REQ-049 Scenario: txEn=1, txStart with txIn=0xA5 -> txOut bit sequence 0,1,0,1,0,0,1,0,1,1, each 1250 clks, then one txDone pulse.
REQ-050 Scenario: reset asserted mid-receive -> rxBusy=0 on the next cycle, rxOut=0x00, no rxDone pulse.
